// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute-stage sequencer: FSM states,
// MIPS opcode/func values, 5-bit ALU op codes and the aluctl/decode layouts.
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_HALT
    } state_t;

    // Operand routing: first name goes to A, second to B.
    typedef enum logic [1:0] {
        SEL_RS_RT,
        SEL_RT_SHAMT,
        SEL_RT_RS,
        SEL_RS_IMM
    } opsel_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_HALT  = 6'b001100;
    localparam logic [5:0] FN_MUL   = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [4:0] ALU_XOR  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SLLV = 5'd2;
    localparam logic [4:0] ALU_SRL  = 5'd3;
    localparam logic [4:0] ALU_SUB  = 5'd4;
    localparam logic [4:0] ALU_SRLV = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SUBU = 5'd8;
    localparam logic [4:0] ALU_OR   = 5'd9;
    localparam logic [4:0] ALU_NOR  = 5'd10;
    localparam logic [4:0] ALU_ADDU = 5'd11;
    localparam logic [4:0] ALU_MUL  = 5'd12;
    localparam logic [4:0] ALU_DIV  = 5'd13;
    localparam logic [4:0] ALU_AND  = 5'd14;
    localparam logic [4:0] ALU_ADD  = 5'd15;
    localparam logic [4:0] ALU_SRA  = 5'd17;
    localparam logic [4:0] ALU_SLTI = 5'd27;
    localparam logic [4:0] ALU_LUI  = 5'd28;

    typedef struct packed {
        logic [4:0] op_code;
        logic       is_itype;
    } aluctl_t;

    typedef struct packed {
        logic    supported;
        logic    halt;
        aluctl_t ctl;
        opsel_t  opsel;
        logic    dest_rt;
    } decode_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational instruction classifier: opcode/func to ALU control, operand
// routing and destination selection. Unlisted encodings report unsupported.
module exec_decode
    import exec_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec       = '0;
        dec.opsel = SEL_RS_RT;
        if (opcode == OP_RTYPE) begin
            dec.supported = 1'b1;
            case (func)
                FN_XOR:  dec.ctl.op_code = ALU_XOR;
                FN_SLL:  begin dec.ctl.op_code = ALU_SLL;  dec.opsel = SEL_RT_SHAMT; end
                FN_SLLV: begin dec.ctl.op_code = ALU_SLLV; dec.opsel = SEL_RT_RS;    end
                FN_SRL:  begin dec.ctl.op_code = ALU_SRL;  dec.opsel = SEL_RT_SHAMT; end
                FN_SUB:  dec.ctl.op_code = ALU_SUB;
                FN_SRLV: begin dec.ctl.op_code = ALU_SRLV; dec.opsel = SEL_RT_RS;    end
                FN_SLT:  dec.ctl.op_code = ALU_SLT;
                FN_SUBU: dec.ctl.op_code = ALU_SUBU;
                FN_OR:   dec.ctl.op_code = ALU_OR;
                FN_NOR:  dec.ctl.op_code = ALU_NOR;
                FN_ADDU: dec.ctl.op_code = ALU_ADDU;
                FN_MUL:  dec.ctl.op_code = ALU_MUL;
                FN_DIV:  dec.ctl.op_code = ALU_DIV;
                FN_AND:  dec.ctl.op_code = ALU_AND;
                FN_ADD:  dec.ctl.op_code = ALU_ADD;
                FN_SRA:  begin dec.ctl.op_code = ALU_SRA;  dec.opsel = SEL_RT_SHAMT; end
                FN_HALT: begin dec.supported = 1'b0; dec.halt = 1'b1; end
                default: dec.supported = 1'b0;
            endcase
        end else begin
            dec.supported    = 1'b1;
            dec.ctl.is_itype = 1'b1;
            dec.opsel        = SEL_RS_IMM;
            dec.dest_rt      = 1'b1;
            case (opcode)
                OP_ADDI:  dec.ctl.op_code = ALU_ADD;
                OP_ADDIU: dec.ctl.op_code = ALU_ADDU;
                OP_ANDI:  dec.ctl.op_code = ALU_AND;
                OP_XORI:  dec.ctl.op_code = ALU_XOR;
                OP_ORI:   dec.ctl.op_code = ALU_OR;
                OP_SLTI:  dec.ctl.op_code = ALU_SLTI;
                OP_LUI:   dec.ctl.op_code = ALU_LUI;
                default:  dec.supported   = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: accept one decoded instruction, issue it to the ALU,
// wait for a variable-latency result (with timeout) and write it back once.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [4:0]  sh_amount,
    input  logic [4:0]  rd_idx,
    input  logic [4:0]  rt_idx,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] seimm,
    output logic [5:0]  aluctl,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        alu_start,
    input  logic [31:0] alu_out_data,
    input  logic        alu_ready,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data_output,
    output logic        halted,
    output logic        err
);

    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nx;
    decode_t       dec;
    logic          err_nx;
    logic [31:0]   op_a, op_b;
    logic [4:0]    dest;
    logic [CW-1:0] wait_cnt;

    exec_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .dec    (dec)
    );

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inst_valid) begin
                    if (dec.halt)           state_nx = ST_HALT;
                    else if (dec.supported) state_nx = ST_ISSUE;
                    else                    err_nx   = 1'b1;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (alu_ready) begin
                    state_nx = ST_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                end
            end
            ST_WB:   state_nx = ST_IDLE;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        op_a = rs_data;
        op_b = rt_data;
        case (dec.opsel)
            SEL_RT_SHAMT: begin op_a = rt_data; op_b = {27'b0, sh_amount}; end
            SEL_RT_RS:    begin op_a = rt_data; op_b = rs_data;            end
            SEL_RS_IMM:   begin op_a = rs_data; op_b = seimm;              end
            default:      begin op_a = rs_data; op_b = rt_data;            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_ready     <= 1'b1;
            alu_start      <= 1'b0;
            rd_we          <= 1'b0;
            halted         <= 1'b0;
            err            <= 1'b0;
            aluctl         <= '0;
            A              <= '0;
            B              <= '0;
            rd_addr        <= '0;
            rd_data_output <= '0;
            dest           <= '0;
            wait_cnt       <= '0;
        end else begin
            inst_ready <= (state_nx == ST_IDLE);
            alu_start  <= (state_nx == ST_ISSUE);
            halted     <= (state_nx == ST_HALT);
            rd_we      <= (state_nx == ST_WB) && (dest != 5'd0);
            err        <= err_nx;
            wait_cnt   <= (state == ST_WAIT) ? wait_cnt + CW'(1) : '0;
            if (state == ST_IDLE && state_nx == ST_ISSUE) begin
                aluctl <= dec.ctl;
                A      <= op_a;
                B      <= op_b;
                dest   <= dec.dest_rt ? rt_idx : rd_idx;
            end
            if (state == ST_WAIT && alu_ready) begin
                rd_addr        <= dest;
                rd_data_output <= alu_out_data;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus randomized
// instructions compared against a table-driven reference of the decode rules.
module tb_exec_sequencer;

    localparam int K_OK    = 0;
    localparam int K_HALT  = 1;
    localparam int K_UNSUP = 2;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
    } inst_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [5:0]  opcode, func;
    logic [4:0]  sh_amount, rd_idx, rt_idx;
    logic [31:0] rs_data, rt_data, seimm;
    logic [5:0]  aluctl;
    logic [31:0] A, B;
    logic        alu_start;
    logic [31:0] alu_out_data;
    logic        alu_ready;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data_output;
    logic        halted;
    logic        err;

    int errors = 0;
    int checks = 0;

    int          r_code[int];
    int          i_code[int];
    logic [5:0]  r_funcs[16];
    logic [5:0]  i_ops[7];

    exec_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .opcode         (opcode),
        .func           (func),
        .sh_amount      (sh_amount),
        .rd_idx         (rd_idx),
        .rt_idx         (rt_idx),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .seimm          (seimm),
        .aluctl         (aluctl),
        .A              (A),
        .B              (B),
        .alu_start      (alu_start),
        .alu_out_data   (alu_out_data),
        .alu_ready      (alu_ready),
        .rd_we          (rd_we),
        .rd_addr        (rd_addr),
        .rd_data_output (rd_data_output),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input inst_t in);
        opcode    = in.opcode;
        func      = in.func;
        sh_amount = in.sh;
        rd_idx    = in.rd;
        rt_idx    = in.rt;
        rs_data   = in.rs_d;
        rt_data   = in.rt_d;
        seimm     = in.imm;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_ready"}, inst_ready, 1);
        check({tag, "_A"}, A, 0);
        check({tag, "_B"}, B, 0);
        check({tag, "_aluctl"}, aluctl, 0);
        check({tag, "_alu_start"}, alu_start, 0);
        check({tag, "_rd_we"}, rd_we, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_data"}, rd_data_output, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Reference: what the instruction should look like on the ALU side.
    task automatic model(input inst_t in, output int kind, output logic [5:0] ctl,
                         output logic [31:0] a, output logic [31:0] b, output logic [4:0] dst);
        kind = K_UNSUP; ctl = '0; a = '0; b = '0; dst = '0;
        if (in.opcode == 6'd0) begin
            if (in.func == 6'b001100) begin
                kind = K_HALT;
            end else if (r_code.exists(int'(in.func))) begin
                kind = K_OK;
                ctl  = {5'(r_code[int'(in.func)]), 1'b0};
                dst  = in.rd;
                if (in.func inside {6'b000000, 6'b000010, 6'b000011}) begin
                    a = in.rt_d; b = {27'd0, in.sh};
                end else if (in.func inside {6'b000100, 6'b000110}) begin
                    a = in.rt_d; b = in.rs_d;
                end else begin
                    a = in.rs_d; b = in.rt_d;
                end
            end
        end else if (i_code.exists(int'(in.opcode))) begin
            kind = K_OK;
            ctl  = {5'(i_code[int'(in.opcode)]), 1'b1};
            dst  = in.rt;
            a    = in.rs_d;
            b    = in.imm;
        end
    endtask

    // Runs one instruction starting in an IDLE cycle; lat = WAIT cycles before alu_ready.
    task automatic run_op(input string tag, input inst_t in, input int lat, input logic [31:0] res);
        int          kind;
        logic [5:0]  ctl;
        logic [31:0] a, b;
        logic [4:0]  dst;
        model(in, kind, ctl, a, b, dst);
        check({tag, "_idle_ready"}, inst_ready, 1);
        drive(in);
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        if (kind != K_OK) begin
            check({tag, "_unsup_err"}, err, 1);
            check({tag, "_unsup_no_start"}, alu_start, 0);
            check({tag, "_unsup_ready"}, inst_ready, 1);
            check({tag, "_unsup_no_we"}, rd_we, 0);
            tick();
            check({tag, "_unsup_err_pulse"}, err, 0);
            return;
        end
        check({tag, "_issue_start"}, alu_start, 1);
        check({tag, "_issue_ready"}, inst_ready, 0);
        check({tag, "_issue_aluctl"}, aluctl, ctl);
        check({tag, "_issue_A"}, A, a);
        check({tag, "_issue_B"}, B, b);
        check({tag, "_issue_err"}, err, 0);
        alu_ready    = 1'b1;
        alu_out_data = ~res;
        tick();
        check({tag, "_wait_start"}, alu_start, 0);
        check({tag, "_wait_we"}, rd_we, 0);
        for (int k = 0; k < lat; k++) begin
            alu_ready = 1'b0;
            tick();
            check({tag, "_wait_we"}, rd_we, 0);
            check({tag, "_wait_ready"}, inst_ready, 0);
            check({tag, "_wait_A"}, A, a);
            check({tag, "_wait_aluctl"}, aluctl, ctl);
        end
        alu_ready    = 1'b1;
        alu_out_data = res;
        tick();
        alu_ready = 1'b0;
        check({tag, "_wb_we"}, rd_we, (dst != 5'd0) ? 1 : 0);
        check({tag, "_wb_addr"}, rd_addr, dst);
        check({tag, "_wb_data"}, rd_data_output, res);
        check({tag, "_wb_err"}, err, 0);
        check({tag, "_wb_ready"}, inst_ready, 0);
        tick();
        check({tag, "_done_we"}, rd_we, 0);
        check({tag, "_done_ready"}, inst_ready, 1);
    endtask

    function automatic inst_t mk(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] rs_d,
                                 input logic [31:0] rt_d, input logic [31:0] imm);
        inst_t t;
        t.opcode = opc; t.func = fn; t.sh = sh; t.rd = rd; t.rt = rt;
        t.rs_d = rs_d; t.rt_d = rt_d; t.imm = imm;
        return t;
    endfunction

    initial begin
        inst_t in;

        r_code[6'b100110] = 0;  r_code[6'b000000] = 1;  r_code[6'b000100] = 2;
        r_code[6'b000010] = 3;  r_code[6'b100010] = 4;  r_code[6'b000110] = 5;
        r_code[6'b101010] = 6;  r_code[6'b100011] = 8;  r_code[6'b100101] = 9;
        r_code[6'b100111] = 10; r_code[6'b100001] = 11; r_code[6'b011000] = 12;
        r_code[6'b011010] = 13; r_code[6'b100100] = 14; r_code[6'b100000] = 15;
        r_code[6'b000011] = 17;
        i_code[6'b001000] = 15; i_code[6'b001001] = 11; i_code[6'b001100] = 14;
        i_code[6'b001110] = 0;  i_code[6'b001101] = 9;  i_code[6'b001010] = 27;
        i_code[6'b001111] = 28;
        r_funcs = '{6'b100110, 6'b000000, 6'b000100, 6'b000010, 6'b100010, 6'b000110,
                    6'b101010, 6'b100011, 6'b100101, 6'b100111, 6'b100001, 6'b011000,
                    6'b011010, 6'b100100, 6'b100000, 6'b000011};
        i_ops   = '{6'b001000, 6'b001001, 6'b001100, 6'b001110, 6'b001101, 6'b001010, 6'b001111};

        rst = 1'b1;
        inst_valid = 1'b0; alu_ready = 1'b0; alu_out_data = '0;
        drive('0);
        tick();
        check_reset_outputs("reset");
        #1 rst = 1'b0;
        tick();

        // add at minimum latency, with literal expectations as a cross-check on the model
        in = mk(6'd0, 6'b100000, 5'd0, 5'd3, 5'd1, 32'd5, 32'd7, 32'd0);
        run_op("add", in, 0, 32'd12);

        in = mk(6'd0, 6'b000000, 5'd4, 5'd5, 5'd2, 32'hDEAD_BEEF, 32'd1, 32'd0);
        drive(in);
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        check("sll_A", A, 1);
        check("sll_B", B, 4);
        check("sll_aluctl", aluctl, 6'b000010);
        alu_ready = 1'b1; alu_out_data = 32'd16;
        tick();
        tick();
        alu_ready = 1'b0;
        check("sll_wb_we", rd_we, 1);
        check("sll_wb_data", rd_data_output, 16);
        tick();

        in = mk(6'b001000, 6'b111111, 5'd0, 5'd30, 5'd9, 32'd10, 32'd0, 32'hFFFF_FFFF);
        run_op("addi", in, 1, 32'd9);
        check("addi_aluctl_lit", aluctl, 6'b011111);
        check("addi_rd_addr_lit", rd_addr, 9);

        in = mk(6'd0, 6'b011010, 5'd0, 5'd17, 5'd4, 32'd100, 32'd7, 32'd0);
        run_op("div20", in, 20, 32'd14);

        in = mk(6'd0, 6'b100001, 5'd0, 5'd0, 5'd4, 32'd1, 32'd2, 32'd0);
        run_op("dest0", in, 2, 32'd3);

        // timeout: alu_ready never arrives
        in = mk(6'd0, 6'b011000, 5'd0, 5'd8, 5'd4, 32'd3, 32'd4, 32'd0);
        drive(in);
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        for (int k = 1; k <= 64; k++) begin
            check("to_wait_err", err, 0);
            check("to_wait_we", rd_we, 0);
            check("to_wait_ready", inst_ready, 0);
            tick();
        end
        check("to_err", err, 1);
        check("to_no_we", rd_we, 0);
        check("to_ready", inst_ready, 1);
        tick();
        check("to_err_pulse", err, 0);
        check("to_after_we", rd_we, 0);

        in = mk(6'b000010, 6'b100000, 5'd0, 5'd3, 5'd3, 32'd1, 32'd1, 32'd1);
        run_op("jump", in, 0, 32'd0);

        // reset in the middle of WAIT
        in = mk(6'd0, 6'b100010, 5'd0, 5'd12, 5'd4, 32'd9, 32'd4, 32'd0);
        drive(in);
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        #1 rst = 1'b0;
        alu_ready = 1'b1; alu_out_data = 32'd5;
        tick();
        check("rst_wait_no_we", rd_we, 0);
        check("rst_wait_no_start", alu_start, 0);
        tick();
        alu_ready = 1'b0;
        check("rst_wait_no_we2", rd_we, 0);

        for (int n = 0; n < 40; n++) begin
            in.rs_d = $urandom; in.rt_d = $urandom; in.imm = $urandom;
            in.sh = 5'($urandom); in.rt = 5'($urandom);
            in.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin in.opcode = 6'd0; in.func = r_funcs[$urandom_range(0, 15)]; end
                5, 6, 7:       begin in.opcode = i_ops[$urandom_range(0, 6)]; in.func = 6'($urandom); end
                default: begin
                    in.opcode = 6'($urandom);
                    in.func   = 6'($urandom);
                    if (in.opcode == 6'd0 && in.func == 6'b001100) in.func = 6'b000001;
                end
            endcase
            run_op("rand", in, $urandom_range(0, 6), $urandom);
        end

        // halt is sticky and ignores new work until reset
        in = mk(6'd0, 6'b001100, 5'd0, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0);
        drive(in);
        inst_valid = 1'b1;
        tick();
        check("halt_flag", halted, 1);
        check("halt_ready", inst_ready, 0);
        in = mk(6'd0, 6'b100000, 5'd0, 5'd3, 5'd1, 32'd5, 32'd7, 32'd0);
        drive(in);
        alu_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("halt_sticky", halted, 1);
            check("halt_no_start", alu_start, 0);
            check("halt_no_we", rd_we, 0);
            check("halt_no_ready", inst_ready, 0);
        end
        inst_valid = 1'b0;
        alu_ready  = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("halt_rst");
        #1 rst = 1'b0;
        tick();

        in = mk(6'd0, 6'b100101, 5'd0, 5'd21, 5'd2, 32'hF0, 32'h0F, 32'd0);
        run_op("post_halt_or", in, 0, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle execute-stage sequencer for the MIPS core: accepts one decoded instruction at a time, selects ALU operands and the 6-bit `aluctl` code, waits for the ALU's `alu_ready` (variable latency for mul/div), then performs a single register-file write-back. It sits between the decode stage and the ALU/register file, replacing ad-hoc combinational write-enable generation with an explicit handshake and a timeout/error path.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before the op is aborted with `err`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `inst_valid`  in  1  decoded instruction present
- `inst_ready`  out  1  sequencer can accept (IDLE only)
- `opcode`, `func`  in  6 each  instruction fields
- `sh_amount`  in  5  shift amount
- `rd_idx`, `rt_idx`  in  5 each  destination candidates
- `rs_data`, `rt_data`, `seimm`  in  32 each  operands / sign-extended immediate
- `aluctl`  out  6  {op_code[4:0], is_itype}
- `A`, `B`  out  32 each  ALU operands
- `alu_start`  out  1  one-cycle start pulse
- `alu_out_data`  in  32  ALU result
- `alu_ready`  in  1  result valid
- `rd_we`  out  1  register write strobe (one cycle)
- `rd_addr`  out  5  write address
- `rd_data_output`  out  32  write data
- `halted`  out  1  sticky halt flag
- `err`  out  1  one-cycle pulse: unsupported op or timeout

## Operation
- States: IDLE, ISSUE, WAIT, WB, HALT.
- IDLE: `inst_ready`=1. On `inst_valid & inst_ready`, latch all inputs and decode. Supported op -> ISSUE. func 001100 with opcode 0 -> HALT. Anything else -> `err` pulse next cycle, stay IDLE.
- R-type codes (opcode 0, by func): xor 100110->0, sll 000000->1, sllv 000100->2, srl 000010->3, sub 100010->4, srlv 000110->5, slt 101010->6, subu 100011->8, or 100101->9, nor 100111->10, addu 100001->11, mul 011000->12, div 011010->13, and 100100->14, add 100000->15, sra 000011->17.
- I-type codes (by opcode): addi 001000->15, addiu 001001->11, andi 001100->14, xori 001110->0, ori 001101->9, slti 001010->27, lui 001111->28. Branch/jump/load/store: unsupported (err).
- Operands: sll/srl/sra: A=rt_data, B={27'b0,sh_amount}; sllv/srlv: A=rt_data, B=rs_data; other R: A=rs_data, B=rt_data; I-type: A=rs_data, B=seimm.
- Destination: R -> `rd_idx`; I -> `rt_idx`. Destination 0: WB still executes, `rd_we` stays 0.
- ISSUE: `alu_start`=1 for exactly one cycle -> WAIT. `A`, `B`, `aluctl` stable from ISSUE through WAIT.
- WAIT: `alu_ready`=1 -> capture `alu_out_data`, go WB. Cycle counter reaches TIMEOUT_CYCLES -> `err` pulse, IDLE, no write.
- WB: `rd_we`=1 (unless dest 0), `rd_addr`/`rd_data_output` valid this cycle -> IDLE.
- HALT: `halted`=1, `inst_ready`=0, ignores all inputs until `rst`.

## Timing
- Reset: state IDLE; `inst_ready`=1; all other outputs 0 (`A`,`B`,`aluctl`,`rd_*`,`halted`,`err`,`alu_start`). Reset in any state aborts the op; no write occurs.
- All outputs registered. `alu_ready` is ignored outside WAIT, including the ISSUE cycle.
- Minimum latency, accept at cycle 0: ISSUE 1, WAIT 2 (alu_ready seen), WB 3 (`rd_we`), IDLE 4. Peak throughput one instruction per 4 cycles.
- Timeout counter is 0 on WAIT entry; `err` asserts in the cycle after the TIMEOUT_CYCLES-th WAIT cycle without `alu_ready`.
- `err` and `rd_we` never assert in the same cycle.

## Structure
- Package `exec_pkg`: state enum, opcode/func localparams, 5-bit ALU op-code localparams, `aluctl` field layout.
- Sub-module `exec_decode`: combinational opcode/func -> {supported, halt, op_code, is_itype, operand select, dest select}; instantiated once.

## Test plan
- add: rs=5, rt=7, rd_idx=3, ALU returns 12 with alu_ready at cycle 2 -> aluctl=6'b011110, A=5, B=7, rd_we=1 at cycle 3, rd_addr=3, data=12.
- sll: rt=1, sh_amount=4 -> A=1, B=4, aluctl=6'b000010; addi rt_idx=9, seimm=0xFFFFFFFF -> aluctl=6'b011111, rd_addr=9.
- div with alu_ready after 20 WAIT cycles -> single rd_we 1 cycle later; inst_ready low throughout.
- alu_ready never asserted -> err pulse after 64 WAIT cycles, no rd_we, inst_ready=1 next cycle.
- func 001100 -> halted=1 sticky, inst_ready=0; later inst_valid ignored; rst clears halted.
- rst asserted mid-WAIT -> all outputs 0 immediately, no write; opcode 000010 (j) -> err pulse, no alu_start.
